// File: rtl/ocp_burst_mem_slave_if.sv
// ocp_burst_mem_slave_if
//   Bundles the request, write-data and response signals of one OCP link.
//   Ports (all carried as interface signals):
//     m_* : driven by the master (command, address, burst, byte enables,
//           write data, write-data tag, response accept)
//     s_* : driven by the slave (command/data accept, response code,
//           last-response flag, read data, echoed tag)
//   Modports: master (drives m_*), slave (drives s_*).
interface ocp_burst_mem_slave_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int BLEN_WIDTH = 4,
   parameter int TAGI_WIDTH = 5
);
   logic [ADDR_WIDTH-1:0]   m_addr;
   logic [BLEN_WIDTH-1:0]   m_burst_length;
   logic [2:0]              m_burst_seq;
   logic [DATA_WIDTH/8-1:0] m_byteen;
   logic [2:0]              m_cmd;
   logic [TAGI_WIDTH-1:0]   m_tagid;
   logic [DATA_WIDTH-1:0]   m_data;
   logic [DATA_WIDTH/8-1:0] m_data_byteen;
   logic                    m_data_valid;
   logic                    m_data_last;
   logic [TAGI_WIDTH-1:0]   m_data_tagid;
   logic                    m_resp_accept;
   logic                    s_cmd_accept;
   logic                    s_data_accept;
   logic [1:0]              s_resp;
   logic                    s_resp_last;
   logic [DATA_WIDTH-1:0]   s_data;
   logic [TAGI_WIDTH-1:0]   s_tagid;

   modport slave (
      input  m_addr, m_burst_length, m_burst_seq, m_byteen, m_cmd, m_tagid,
             m_data, m_data_byteen, m_data_valid, m_data_last, m_data_tagid,
             m_resp_accept,
      output s_cmd_accept, s_data_accept, s_resp, s_resp_last, s_data, s_tagid
   );

   modport master (
      output m_addr, m_burst_length, m_burst_seq, m_byteen, m_cmd, m_tagid,
             m_data, m_data_byteen, m_data_valid, m_data_last, m_data_tagid,
             m_resp_accept,
      input  s_cmd_accept, s_data_accept, s_resp, s_resp_last, s_data, s_tagid
   );
endinterface

// File: rtl/ocp_burst_mem_slave.sv
// ocp_burst_mem_slave
//   Word-organised on-chip memory behind an OCP slave port. Supports INCR,
//   WRAP and STRM bursts, request/beat byte enables, tag echo, non-posted
//   write responses and read-response backpressure.
//   Ports:
//     clk       : clock, rising edge
//     rst       : synchronous active-high reset (memory contents persist)
//     bus       : OCP link, slave modport
//     err_count : saturating count of errored commands
module ocp_burst_mem_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int BLEN_WIDTH = 4,
   parameter int TAGI_WIDTH = 5,
   parameter int DEPTH      = 256
) (
   input  logic                   clk,
   input  logic                   rst,
   ocp_burst_mem_slave_if.slave   bus,
   output logic [7:0]             err_count
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFF   = (BYTES > 1) ? $clog2(BYTES) : 0;
   localparam int AW    = $clog2(DEPTH);
   localparam int XW    = ADDR_WIDTH + BLEN_WIDTH + 1;

   localparam logic [2:0] CMD_IDLE = 3'd0, CMD_WR = 3'd1, CMD_RD = 3'd2,
                          CMD_RDEX = 3'd3, CMD_RDL = 3'd4, CMD_WRNP = 3'd5,
                          CMD_WRC = 3'd6, CMD_BCST = 3'd7;
   localparam logic [2:0] SEQ_INCR = 3'd0, SEQ_WRAP = 3'd2, SEQ_STRM = 3'd5;
   localparam logic [1:0] RESP_NULL = 2'd0, RESP_DVA = 2'd1,
                          RESP_FAIL = 2'd2, RESP_ERR = 2'd3;

   typedef enum logic [2:0] {S_IDLE, S_WDATA, S_RFETCH, S_RDATA, S_RESP} state_t;

   state_t                  state_reg, state_next;
   logic [AW-1:0]           idx_reg;
   logic [BLEN_WIDTH-1:0]   len_reg;
   logic [2:0]              seq_reg;
   logic [BYTES-1:0]        byteen_reg;
   logic [TAGI_WIDTH-1:0]   tag_reg;
   logic [2:0]              cmd_reg;
   logic                    err_reg;
   logic [BLEN_WIDTH-1:0]   beat_reg;
   logic [7:0]              err_count_reg;
   logic [DATA_WIDTH-1:0]   rdata_reg;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic [ADDR_WIDTH-1:0]   cmd_idx;
   logic [XW-1:0]           cmd_end;
   logic                    cmd_fire, cmd_err, cmd_is_write, cmd_is_read;
   logic                    last_beat, beat_err, wbeat, count_err;
   logic                    wr_en, rd_en;
   logic [BLEN_WIDTH-1:0]   k_sel;
   logic [AW-1:0]           mem_addr;
   logic [BYTES-1:0]        wr_mask;

   // Word address of beat k of a burst starting at word base.
   function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] base,
                                               input logic [BLEN_WIDTH-1:0] len,
                                               input logic [2:0] seq,
                                               input logic [BLEN_WIDTH-1:0] k);
      logic [AW-1:0] mask;
      mask = AW'(len) - AW'(1);
      case (seq)
         SEQ_INCR: beat_addr = base + AW'(k);
         SEQ_WRAP: beat_addr = (base & ~mask) | ((base + AW'(k)) & mask);
         default:  beat_addr = base;
      endcase
   endfunction

   // Command decode and error checks on the incoming request.
   always_comb begin
      cmd_idx      = bus.m_addr >> OFF;
      cmd_end      = XW'(cmd_idx) + XW'(bus.m_burst_length) - XW'(1);
      cmd_fire     = (state_reg == S_IDLE) && (bus.m_cmd != CMD_IDLE);
      cmd_is_write = (bus.m_cmd == CMD_WR) || (bus.m_cmd == CMD_WRNP) ||
                     (bus.m_cmd == CMD_WRC) || (bus.m_cmd == CMD_BCST);
      cmd_is_read  = !cmd_is_write && (bus.m_cmd != CMD_IDLE);
      cmd_err      = (bus.m_burst_length == '0) ||
                     !((bus.m_burst_seq == SEQ_INCR) || (bus.m_burst_seq == SEQ_WRAP) ||
                       (bus.m_burst_seq == SEQ_STRM)) ||
                     ((bus.m_burst_seq == SEQ_WRAP) &&
                      ((bus.m_burst_length & (bus.m_burst_length - BLEN_WIDTH'(1))) != '0)) ||
                     ((bus.m_burst_seq == SEQ_INCR) && (cmd_end >= XW'(DEPTH))) ||
                     (XW'(cmd_idx) >= XW'(DEPTH)) ||
                     (bus.m_cmd == CMD_RDEX) || (bus.m_cmd == CMD_RDL) ||
                     (bus.m_cmd == CMD_WRC) || (bus.m_cmd == CMD_BCST);
   end

   // Beat bookkeeping and memory port control.
   always_comb begin
      last_beat = (beat_reg == len_reg - BLEN_WIDTH'(1));
      beat_err  = (bus.m_data_last != last_beat) || (bus.m_data_tagid != tag_reg);
      wbeat     = (state_reg == S_WDATA) && bus.m_data_valid;
      // A command is counted once: at capture, or at its first beat error.
      count_err = (cmd_fire && cmd_err) || (wbeat && beat_err && !err_reg);
      wr_en     = wbeat && !err_reg;
      wr_mask   = byteen_reg & bus.m_data_byteen;
      // The read port is advanced only when the presented beat is consumed,
      // so rdata_reg (and thus s_data) holds still under backpressure.
      rd_en     = (state_reg == S_RFETCH) ||
                  ((state_reg == S_RDATA) && bus.m_resp_accept && !last_beat);
      k_sel     = (state_reg == S_RDATA) ? beat_reg + BLEN_WIDTH'(1) : beat_reg;
      mem_addr  = beat_addr(idx_reg, len_reg, seq_reg, k_sel);
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (cmd_fire) begin
               if (cmd_is_write)
                  state_next = (bus.m_burst_length == '0) ? S_RESP : S_WDATA;
               else if (cmd_is_read)
                  state_next = cmd_err ? S_RESP : S_RFETCH;
            end
         end
         S_WDATA: begin
            if (wbeat && last_beat)
               state_next = ((cmd_reg == CMD_WR) && !err_reg && !beat_err) ? S_IDLE : S_RESP;
         end
         S_RFETCH: state_next = S_RDATA;
         S_RDATA: begin
            if (bus.m_resp_accept && last_beat)
               state_next = S_IDLE;
         end
         S_RESP: begin
            if (bus.m_resp_accept)
               state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         idx_reg       <= '0;
         len_reg       <= '0;
         seq_reg       <= '0;
         byteen_reg    <= '0;
         tag_reg       <= '0;
         cmd_reg       <= CMD_IDLE;
         err_reg       <= 1'b0;
         beat_reg      <= '0;
         err_count_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (cmd_fire) begin
            idx_reg    <= cmd_idx[AW-1:0];
            len_reg    <= bus.m_burst_length;
            seq_reg    <= bus.m_burst_seq;
            byteen_reg <= bus.m_byteen;
            tag_reg    <= bus.m_tagid;
            cmd_reg    <= bus.m_cmd;
            err_reg    <= cmd_err;
            beat_reg   <= '0;
         end else if (wbeat) begin
            beat_reg <= beat_reg + BLEN_WIDTH'(1);
            if (beat_err)
               err_reg <= 1'b1;
         end else if ((state_reg == S_RDATA) && bus.m_resp_accept && !last_beat) begin
            beat_reg <= beat_reg + BLEN_WIDTH'(1);
         end
         if (count_err && (err_count_reg != 8'hFF))
            err_count_reg <= err_count_reg + 8'd1;
      end
   end

   // Memory array: not reset, single shared address port, registered read.
   always_ff @(posedge clk) begin
      for (int b = 0; b < BYTES; b++) begin
         if (wr_en && wr_mask[b])
            mem[mem_addr][b*8 +: 8] <= bus.m_data[b*8 +: 8];
      end
      if (rd_en)
         rdata_reg <= mem[mem_addr];
   end

   // Outputs.
   always_comb begin
      bus.s_cmd_accept  = (state_reg == S_IDLE) && !rst;
      bus.s_data_accept = (state_reg == S_WDATA);
      bus.s_resp        = RESP_NULL;
      bus.s_resp_last   = 1'b0;
      bus.s_data        = '0;
      bus.s_tagid       = tag_reg;
      if (state_reg == S_RDATA) begin
         bus.s_resp      = RESP_DVA;
         bus.s_resp_last = last_beat;
         bus.s_data      = rdata_reg;
      end else if (state_reg == S_RESP) begin
         bus.s_resp_last = 1'b1;
         if (cmd_reg == CMD_WRC)
            bus.s_resp = RESP_FAIL;
         else if ((cmd_reg == CMD_WRNP) && !err_reg)
            bus.s_resp = RESP_DVA;
         else
            bus.s_resp = RESP_ERR;
      end
   end

   assign err_count = err_count_reg;
endmodule

// File: tb/tb_ocp_burst_mem_slave.sv
// tb_ocp_burst_mem_slave
//   Directed testbench for ocp_burst_mem_slave: write/read bursts, WRAP,
//   backpressure, byte enables, error responses and reset mid-burst.
module tb_ocp_burst_mem_slave;
   localparam logic [2:0] C_WR = 3'd1, C_RD = 3'd2, C_WRNP = 3'd5, C_WRC = 3'd6;
   localparam logic [2:0] Q_INCR = 3'd0, Q_WRAP = 3'd2, Q_STRM = 3'd5;
   localparam int R_NULL = 0, R_DVA = 1, R_FAIL = 2, R_ERR = 3;

   logic       clk;
   logic       rst;
   logic [7:0] err_count;
   int         vectors = 0;
   int         miscompares = 0;

   ocp_burst_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .BLEN_WIDTH(4),
                            .TAGI_WIDTH(5)) bus ();

   ocp_burst_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .BLEN_WIDTH(4),
                         .TAGI_WIDTH(5), .DEPTH(256)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one command in IDLE and let it be captured on the next edge.
   task automatic issue_cmd(input logic [2:0] cmd, input int idx, input int len,
                            input logic [2:0] seq, input logic [4:0] tag);
      bus.m_cmd          = cmd;
      bus.m_addr         = 12'(idx * 4);
      bus.m_burst_length = 4'(len);
      bus.m_burst_seq    = seq;
      bus.m_byteen       = 4'hF;
      bus.m_tagid        = tag;
      chk("cmd_accept", 32'(bus.s_cmd_accept), 1);
      tick();
      bus.m_cmd = 3'd0;
   endtask

   // Single-beat response in RESP: check it, accept it, check return to IDLE.
   task automatic expect_resp(input int code, input logic [4:0] tag);
      chk("resp_code", 32'(bus.s_resp), 32'(code));
      chk("resp_last", 32'(bus.s_resp_last), 1);
      chk("resp_tag", 32'(bus.s_tagid), 32'(tag));
      chk("resp_data0", bus.s_data, 0);
      bus.m_resp_accept = 1'b1;
      tick();
      bus.m_resp_accept = 1'b0;
      chk("resp_idle", 32'(bus.s_resp), R_NULL);
      chk("resp_cmd_accept", 32'(bus.s_cmd_accept), 1);
      $display("txn resp code %0d tag %0d err_count %0d", code, tag, err_count);
   endtask

   // Write burst; d/be hold beat k at bits [k*32 +: 32] / [k*4 +: 4].
   task automatic do_write(input logic [2:0] cmd, input int idx, input int len,
                           input logic [2:0] seq, input logic [4:0] tag,
                           input int early_last, input logic [127:0] d,
                           input logic [15:0] be);
      issue_cmd(cmd, idx, len, seq, tag);
      for (int k = 0; k < len; k++) begin
         bus.m_data_valid  = 1'b1;
         bus.m_data        = d[k*32 +: 32];
         bus.m_data_byteen = be[k*4 +: 4];
         bus.m_data_last   = (early_last >= 0) ? (k == early_last) : (k == len - 1);
         bus.m_data_tagid  = tag;
         if (k == 0)
            chk("data_accept", 32'(bus.s_data_accept), 1);
         tick();
      end
      bus.m_data_valid = 1'b0;
      bus.m_data_last  = 1'b0;
      $display("txn write cmd %0d idx %0d len %0d seq %0d", cmd, idx, len, seq);
   endtask

   // Read burst; e holds expected beat k at bits [k*32 +: 32].
   task automatic do_read(input int idx, input int len, input logic [2:0] seq,
                          input logic [4:0] tag, input int hold_beat, input int hold_n,
                          input logic [127:0] e);
      issue_cmd(C_RD, idx, len, seq, tag);
      chk("rd_latency_c1", 32'(bus.s_resp), R_NULL);
      bus.m_resp_accept = 1'b1;
      tick();
      for (int k = 0; k < len; k++) begin
         chk("rd_resp", 32'(bus.s_resp), R_DVA);
         chk("rd_data", bus.s_data, e[k*32 +: 32]);
         chk("rd_last", 32'(bus.s_resp_last), 32'(k == len - 1));
         chk("rd_tag", 32'(bus.s_tagid), 32'(tag));
         if (k == hold_beat) begin
            bus.m_resp_accept = 1'b0;
            for (int h = 0; h < hold_n; h++) begin
               tick();
               chk("hold_resp", 32'(bus.s_resp), R_DVA);
               chk("hold_data", bus.s_data, e[k*32 +: 32]);
               chk("hold_last", 32'(bus.s_resp_last), 32'(k == len - 1));
            end
            bus.m_resp_accept = 1'b1;
         end
         tick();
      end
      bus.m_resp_accept = 1'b0;
      chk("rd_done_null", 32'(bus.s_resp), R_NULL);
      chk("rd_done_accept", 32'(bus.s_cmd_accept), 1);
      $display("txn read idx %0d len %0d seq %0d tag %0d", idx, len, seq, tag);
   endtask

   initial begin
      rst                = 1'b1;
      bus.m_addr         = '0;
      bus.m_burst_length = '0;
      bus.m_burst_seq    = '0;
      bus.m_byteen       = '0;
      bus.m_cmd          = '0;
      bus.m_tagid        = '0;
      bus.m_data         = '0;
      bus.m_data_byteen  = '0;
      bus.m_data_valid   = 1'b0;
      bus.m_data_last    = 1'b0;
      bus.m_data_tagid   = '0;
      bus.m_resp_accept  = 1'b0;
      tick();
      tick();

      // Reset values
      chk("rst_cmd_accept", 32'(bus.s_cmd_accept), 0);
      chk("rst_data_accept", 32'(bus.s_data_accept), 0);
      chk("rst_resp", 32'(bus.s_resp), R_NULL);
      chk("rst_resp_last", 32'(bus.s_resp_last), 0);
      chk("rst_data", bus.s_data, 0);
      chk("rst_tagid", 32'(bus.s_tagid), 0);
      chk("rst_err_count", 32'(err_count), 0);
      rst = 1'b0;
      #1;
      chk("post_rst_accept", 32'(bus.s_cmd_accept), 1);
      $display("txn reset released");

      // WRNP INCR idx 4 len 4, then read back
      do_write(C_WRNP, 4, 4, Q_INCR, 5'd3, -1,
               {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 16'hFFFF);
      expect_resp(R_DVA, 5'd3);
      do_read(4, 4, Q_INCR, 5'd9, -1, 0, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

      // WRAP read idx 6 len 4 -> words 6,7,4,5
      do_read(6, 4, Q_WRAP, 5'd4, -1, 0, {32'hA1, 32'hA0, 32'hA3, 32'hA2});
      // WRAP len 3 is illegal
      issue_cmd(C_RD, 6, 3, Q_WRAP, 5'd5);
      expect_resp(R_ERR, 5'd5);
      chk("err_count_wrap3", 32'(err_count), 1);

      // Backpressure: beat 1 held for 3 cycles
      do_read(4, 4, Q_INCR, 5'd6, 1, 3, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

      // Posted STRM write with beat byte enables; no response expected
      do_write(C_WR, 2, 3, Q_STRM, 5'd7, -1,
               {32'h0, 32'h33333333, 32'h22222222, 32'h11111111}, 16'h0C21);
      chk("wr_no_resp", 32'(bus.s_resp), R_NULL);
      chk("wr_idle", 32'(bus.s_cmd_accept), 1);
      do_read(2, 1, Q_STRM, 5'd8, -1, 0, {96'h0, 32'h33332211});

      // Boundary: fill 252..255, then an overrunning INCR must change nothing
      do_write(C_WRNP, 252, 4, Q_INCR, 5'd10, -1,
               {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 16'hFFFF);
      expect_resp(R_DVA, 5'd10);
      do_write(C_WRNP, 254, 4, Q_INCR, 5'd11, -1,
               {32'hDEAD3, 32'hDEAD2, 32'hDEAD1, 32'hDEAD0}, 16'hFFFF);
      expect_resp(R_ERR, 5'd11);
      chk("err_count_bound", 32'(err_count), 2);
      do_read(252, 4, Q_INCR, 5'd12, -1, 0, {32'hC3, 32'hC2, 32'hC1, 32'hC0});

      // Early m_data_last on beat 1 of 3 -> ERR after all 3 beats
      do_write(C_WRNP, 8, 3, Q_INCR, 5'd13, 1,
               {32'h0, 32'hE2, 32'hE1, 32'hE0}, 16'h0FFF);
      expect_resp(R_ERR, 5'd13);
      chk("err_count_last", 32'(err_count), 3);

      // WRC -> FAIL
      do_write(C_WRC, 10, 1, Q_INCR, 5'd14, -1, {96'h0, 32'hF0}, 16'h000F);
      expect_resp(R_FAIL, 5'd14);
      chk("err_count_wrc", 32'(err_count), 4);

      // Reset during beat 2 of a len-8 read
      issue_cmd(C_RD, 4, 8, Q_INCR, 5'd15);
      bus.m_resp_accept = 1'b1;
      tick();
      chk("rr_beat0", bus.s_data, 32'hA0);
      tick();
      chk("rr_beat1", bus.s_data, 32'hA1);
      tick();
      chk("rr_beat2_resp", 32'(bus.s_resp), R_DVA);
      rst = 1'b1;
      bus.m_resp_accept = 1'b0;
      tick();
      chk("rr_resp_null", 32'(bus.s_resp), R_NULL);
      chk("rr_data0", bus.s_data, 0);
      chk("rr_accept_in_rst", 32'(bus.s_cmd_accept), 0);
      chk("rr_err_count", 32'(err_count), 0);
      rst = 1'b0;
      #1;
      chk("rr_accept_after", 32'(bus.s_cmd_accept), 1);
      $display("txn reset mid-read");
      do_read(4, 4, Q_INCR, 5'd16, -1, 0, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
